// File: rtl/definitions_pkg.sv
// definitions_pkg: shared types and constants for the Booth multiply/divide datapaths
package definitions_pkg;
    localparam int DATA_W = 8;
    localparam int DIV_ITERS = 8;
    typedef logic signed [DATA_W-1:0] int8_t;
    typedef logic [3:0] cnt_t;
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ITER = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } div_state_e;
endpackage

// File: rtl/booth_div_seq_sign_mag_abs.sv
// sign_mag_abs: splits a signed operand into unsigned magnitude and sign (-128 -> 8'h80)
module sign_mag_abs
    import definitions_pkg::*;
(
    input  int8_t      i_val,
    output logic [7:0] o_mag,
    output logic       o_sign
);
    // magnitude wraps naturally for -128, giving the unsigned value 128
    always_comb begin
        o_sign = i_val[7];
        o_mag  = i_val[7] ? -i_val : i_val;
    end
endmodule

// File: rtl/booth_div_seq.sv
// booth_div_seq: sequential signed restoring divider with start/rdy handshake
module booth_div_seq
    import definitions_pkg::*;
#(
    parameter int WIDTH = DATA_W
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_start,
    input  int8_t      i_dividend,
    input  int8_t      i_divisor,
    output int8_t      o_quotient,
    output int8_t      o_remainder,
    output logic       o_rdy,
    output logic       o_busy,
    output logic       o_div_by_zero,
    output logic       o_ovf,
    output cnt_t       o_cnt,
    output div_state_e o_Edo_Act
);
    div_state_e       state_q, state_d;
    logic [WIDTH:0]   a_q, a_d, a_sh;
    logic [WIDTH-1:0] q_q, q_d, m_q, m_d;
    logic [WIDTH+1:0] t;
    cnt_t             cnt_q, cnt_d;
    int8_t            dvd_q, dvd_d, quot_q, quot_d, rem_q, rem_d;
    logic             sd_q, sd_d, sv_q, sv_d, dz_q, dz_d, ovp_q, ovp_d;
    logic             dzo_q, dzo_d, ovf_q, ovf_d;
    logic [7:0]       dvd_mag, dvs_mag;
    logic             dvd_sign, dvs_sign;

    sign_mag_abs u_abs_dvd (.i_val(i_dividend), .o_mag(dvd_mag), .o_sign(dvd_sign));
    sign_mag_abs u_abs_dvs (.i_val(i_divisor),  .o_mag(dvs_mag), .o_sign(dvs_sign));

    // next-state: operand capture, one restoring step per ITER cycle, sign fix, handshake
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        q_d     = q_q;
        m_d     = m_q;
        cnt_d   = cnt_q;
        dvd_d   = dvd_q;
        sd_d    = sd_q;
        sv_d    = sv_q;
        dz_d    = dz_q;
        ovp_d   = ovp_q;
        quot_d  = quot_q;
        rem_d   = rem_q;
        dzo_d   = dzo_q;
        ovf_d   = ovf_q;
        a_sh    = {a_q[WIDTH-1:0], q_q[WIDTH-1]};
        t       = {1'b0, a_sh} - {2'b00, m_q};
        case (state_q)
            IDLE: if (i_start) begin
                dvd_d   = i_dividend;
                sd_d    = dvd_sign;
                sv_d    = dvs_sign;
                a_d     = '0;
                q_d     = dvd_mag;
                m_d     = dvs_mag;
                cnt_d   = '0;
                dz_d    = i_divisor == 0;
                ovp_d   = i_dividend == int8_t'(8'h80) && i_divisor == int8_t'(8'hFF);
                state_d = i_divisor == 0 ? FIX : ITER;
            end
            ITER: begin
                a_d     = t[WIDTH+1] ? a_sh : t[WIDTH:0];
                q_d     = {q_q[WIDTH-2:0], ~t[WIDTH+1]};
                cnt_d   = cnt_q + 1'b1;
                state_d = cnt_q == cnt_t'(DIV_ITERS - 1) ? FIX : ITER;
            end
            FIX: begin
                quot_d  = dz_q ? int8_t'(8'hFF) : ovp_q ? int8_t'(8'h80) :
                          (sd_q ^ sv_q) ? -q_q : q_q;
                rem_d   = dz_q ? dvd_q : ovp_q ? int8_t'(8'h00) :
                          sd_q ? -a_q[WIDTH-1:0] : a_q[WIDTH-1:0];
                dzo_d   = dz_q;
                ovf_d   = ovp_q;
                state_d = DONE;
            end
            default: if (!i_start) begin
                dzo_d   = 1'b0;
                ovf_d   = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    // state and datapath registers; reset aborts any division in flight
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            q_q     <= '0;
            m_q     <= '0;
            cnt_q   <= '0;
            dvd_q   <= '0;
            sd_q    <= 1'b0;
            sv_q    <= 1'b0;
            dz_q    <= 1'b0;
            ovp_q   <= 1'b0;
            quot_q  <= '0;
            rem_q   <= '0;
            dzo_q   <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            q_q     <= q_d;
            m_q     <= m_d;
            cnt_q   <= cnt_d;
            dvd_q   <= dvd_d;
            sd_q    <= sd_d;
            sv_q    <= sv_d;
            dz_q    <= dz_d;
            ovp_q   <= ovp_d;
            quot_q  <= quot_d;
            rem_q   <= rem_d;
            dzo_q   <= dzo_d;
            ovf_q   <= ovf_d;
        end
    end

    // outputs: handshake flags decoded from state, results from the output registers
    always_comb begin
        o_quotient    = quot_q;
        o_remainder   = rem_q;
        o_rdy         = state_q == DONE;
        o_busy        = state_q == ITER || state_q == FIX;
        o_div_by_zero = dzo_q;
        o_ovf         = ovf_q;
        o_cnt         = cnt_q;
        o_Edo_Act     = state_q;
    end
endmodule

// File: tb/tb_booth_div_seq.sv
// tb_booth_div_seq: directed scoreboard bench for the signed sequential divider
module tb_booth_div_seq;
    import definitions_pkg::*;

    typedef struct {
        int8_t q;
        int8_t r;
        logic  dz;
        logic  ovf;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       i_start = 1'b0;
    int8_t      i_dividend = '0;
    int8_t      i_divisor = '0;
    int8_t      o_quotient, o_remainder;
    logic       o_rdy, o_busy, o_div_by_zero, o_ovf;
    cnt_t       o_cnt;
    div_state_e o_Edo_Act;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;

    booth_div_seq dut (
        .clk(clk), .rst(rst), .i_start(i_start),
        .i_dividend(i_dividend), .i_divisor(i_divisor),
        .o_quotient(o_quotient), .o_remainder(o_remainder),
        .o_rdy(o_rdy), .o_busy(o_busy), .o_div_by_zero(o_div_by_zero),
        .o_ovf(o_ovf), .o_cnt(o_cnt), .o_Edo_Act(o_Edo_Act)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input int8_t a, input int8_t b);
        exp_t e;
        int   ia, ib;
        ia = a;
        ib = b;
        e.dz  = 1'b0;
        e.ovf = 1'b0;
        if (ib == 0) begin
            e.q  = -8'sd1;
            e.r  = a;
            e.dz = 1'b1;
        end else if (ia == -128 && ib == -1) begin
            e.q   = a;
            e.r   = '0;
            e.ovf = 1'b1;
        end else begin
            e.q = int8_t'(ia / ib);
            e.r = int8_t'(ia % ib);
        end
        return e;
    endfunction

    task automatic run_div(input int8_t a, input int8_t b, input int hold, input int linger);
        exp_t e;
        int   edges, busy_n;
        e = model(a, b);
        sb.push_back(e);
        @(negedge clk);
        i_dividend = a;
        i_divisor  = b;
        i_start    = 1'b1;
        edges      = 0;
        busy_n     = 0;
        while (edges < 20) begin
            @(posedge clk);
            edges++;
            @(negedge clk);
            if (edges == 1) begin
                i_dividend = int8_t'($urandom);
                i_divisor  = int8_t'($urandom);
            end
            if (edges >= hold) i_start = 1'b0;
            if (o_busy) busy_n++;
            if (o_rdy) break;
        end
        chk("latency", edges, b == 0 ? 2 : 10);
        chk("busy_cycles", busy_n, b == 0 ? 1 : 9);
        if (o_rdy && sb.size() > 0) begin
            e = sb.pop_front();
            chk("quotient", o_quotient, e.q);
            chk("remainder", o_remainder, e.r);
            chk("div_by_zero", o_div_by_zero, e.dz);
            chk("ovf", o_ovf, e.ovf);
        end
        for (int i = 0; i < linger; i++) begin
            @(posedge clk);
            @(negedge clk);
            chk("rdy_hold", o_rdy, 1);
            chk("state_hold", o_Edo_Act, DONE);
        end
        i_start = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("rdy_clear", o_rdy, 0);
        chk("state_idle", o_Edo_Act, IDLE);
        chk("flags_clear", {o_div_by_zero, o_ovf}, 0);
        chk("quot_kept", o_quotient, e.q);
        chk("rem_kept", o_remainder, e.r);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_state", o_Edo_Act, IDLE);
        chk("rst_outs", {o_quotient, o_remainder, o_rdy, o_busy, o_div_by_zero, o_ovf, o_cnt}, 0);
        rst = 1'b0;

        run_div(8'sd100, 8'sd7, 2, 0);
        run_div(-8'sd100, 8'sd7, 1, 0);
        run_div(8'sd100, -8'sd7, 1, 0);
        run_div(-8'sd100, -8'sd7, 1, 0);
        run_div(int8_t'(8'h80), 8'sd127, 1, 0);
        run_div(8'sd127, int8_t'(8'h80), 1, 0);
        run_div(int8_t'(8'h80), -8'sd1, 1, 0);
        run_div(8'sd37, 8'sd0, 1, 0);
        run_div(8'sd9, 8'sd3, 1, 0);
        run_div(-8'sd45, 8'sd0, 99, 3);
        run_div(8'sd53, -8'sd6, 99, 4);

        @(negedge clk);
        i_dividend = 8'sd100;
        i_divisor  = 8'sd7;
        i_start    = 1'b1;
        repeat (4) @(posedge clk);
        i_start = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("abort_state", o_Edo_Act, IDLE);
        chk("abort_outs", {o_quotient, o_remainder, o_rdy, o_busy, o_div_by_zero, o_ovf, o_cnt}, 0);
        @(negedge clk);
        rst = 1'b0;
        run_div(8'sd50, 8'sd5, 1, 0);

        chk("sb_drained", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
